// File: rtl/dp_rr_scheduler.sv
// -----------------------------------------------------------------------------
// dp_rr_scheduler
//   Shares one two-register-stage compare datapath (4-bit operand in, 3-bit
//   result out) among NREQ requesters. One requester is granted per cycle in
//   round-robin order, and its operand goes onto dp_i. A {valid, id} tag pipe
//   that is LAT stages deep follows each operand through the datapath, so that
//   each result on dp_s comes back tagged with the requester that owns it.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   LAT   datapath latency in clock edges (>=1)
//   IDW   width of rsp_id (2**IDW >= NREQ)
//
// Ports
//   CLK, RST_N     clock (rising edge), asynchronous active-low reset
//   en             accept and issue requests
//   flush          1-cycle pulse: stop issuing, drain in-flight, pulse done
//   req/req_data   per-requester request and 4-bit operand ([4k+3:4k])
//   gnt            one-hot grant (combinational)
//   dp_i / dp_s    datapath operand out / datapath result in
//   rsp_valid/id   registered response qualifier and owner id
//   rsp_data       dp_s when rsp_valid, else 0
//   busy, done     activity flag, end-of-drain pulse
//   stats_gnt/stall saturating statistics counters
//
// Build option
//   DP_SCHED_STATS_EN  builds the saturating grant/stall counters; when it is
//                      not defined both stats outputs are tied to zero.
//
// FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | not issuing; waits for en
//   S_RUN    | issuing grants while en=1
//   S_DRAIN  | flush seen; no grants, waiting for the tag pipe to empty
// -----------------------------------------------------------------------------
module dp_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int IDW  = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              en,
    input  logic              flush,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [3:0]        dp_i,
    input  logic [2:0]        dp_s,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [2:0]        rsp_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       stats_gnt,
    output logic [15:0]       stats_stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [LAT-1:0]  r_tag_v;
    logic [IDW-1:0]  r_tag_id [LAT];
    logic            r_idle_flush;

    logic            w_grant_en;
    logic            w_found;
    logic            w_any_gnt;
    logic            w_tags_empty;
    logic            w_drain_done;
    logic [IDW-1:0]  w_win_id;
    logic [NREQ-1:0] w_gnt;
    logic [3:0]      w_dp_i;

    // Grants are only issued in RUN with en high; a flush pulse in RUN
    // blocks the grant in that same cycle.
    assign w_grant_en   = (r_state == S_RUN) && en && !flush;
    assign w_tags_empty = ~|r_tag_v;

    // Round-robin search. The first pass looks at requesters at or above the
    // pointer and the second pass at those below it, which gives the wrapped
    // search order without a variable rotate.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[k] && (k >= int'(r_ptr))) begin
                w_found  = 1'b1;
                w_win_id = IDW'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[k] && (k < int'(r_ptr))) begin
                w_found  = 1'b1;
                w_win_id = IDW'(k);
            end
        end
    end

    always_comb begin
        w_gnt  = '0;
        w_dp_i = 4'b0000;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant_en && w_found && (w_win_id == IDW'(k))) begin
                w_gnt[k] = 1'b1;
                w_dp_i   = req_data[4*k +: 4];
            end
        end
    end

    assign w_any_gnt = |w_gnt;
    assign gnt       = w_gnt;
    assign dp_i      = w_dp_i;

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_any_gnt) begin
            w_ptr_nxt = (int'(w_win_id) == NREQ - 1) ? '0 : (w_win_id + IDW'(1));
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_drain_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && !flush) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_nxt = S_DRAIN;
                end else if (!en && w_tags_empty) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_tags_empty) begin
                    w_state_nxt  = S_IDLE;
                    w_drain_done = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_idle_flush <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_idle_flush <= (r_state == S_IDLE) && flush;
        end
    end

    // The tag pipe advances every cycle in lock-step with the unstalled
    // datapath. The id is zeroed on empty slots so that rsp_id reads 0
    // whenever no response is valid.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tag_v <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_any_gnt;
            r_tag_id[0] <= w_any_gnt ? w_win_id : '0;
            for (int k = 1; k < LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    assign rsp_valid = r_tag_v[LAT-1];
    assign rsp_id    = r_tag_id[LAT-1];
    // The datapath has no reset, so dp_s is only passed out while a tag
    // vouches for it.
    assign rsp_data  = rsp_valid ? dp_s : 3'b000;

    // A flush in IDLE is acknowledged one cycle later through r_idle_flush;
    // a drain is acknowledged in the cycle that leaves DRAIN.
    assign done = w_drain_done | r_idle_flush;
    assign busy = (r_state != S_IDLE) | ~w_tags_empty;

`ifdef DP_SCHED_STATS_EN
    logic [15:0] r_stats_gnt;
    logic [15:0] r_stats_stall;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stats_gnt   <= 16'h0000;
            r_stats_stall <= 16'h0000;
        end else begin
            if (w_any_gnt && (r_stats_gnt != 16'hFFFF)) begin
                r_stats_gnt <= r_stats_gnt + 16'd1;
            end
            if ((|req) && !w_any_gnt && (r_stats_stall != 16'hFFFF)) begin
                r_stats_stall <= r_stats_stall + 16'd1;
            end
        end
    end

    assign stats_gnt   = r_stats_gnt;
    assign stats_stall = r_stats_stall;
`else
    assign stats_gnt   = 16'h0000;
    assign stats_stall = 16'h0000;
`endif

endmodule

// File: tb/tb_dp_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dp_rr_scheduler
//   Directed stimulus for dp_rr_scheduler. The bench contains its own
//   two-stage datapath model. Each expected grant pushes the owner id and the
//   expected datapath result into a scoreboard queue. A negedge monitor pops
//   that queue whenever rsp_valid is high and also checks the response cycle.
// -----------------------------------------------------------------------------
module tb_dp_rr_scheduler;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int IDW  = 3;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              en;
    logic              flush;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [3:0]        dp_i;
    logic [2:0]        dp_s;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [2:0]        rsp_data;
    logic              busy;
    logic              done;
    logic [15:0]       stats_gnt;
    logic [15:0]       stats_stall;

    dp_rr_scheduler #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .en         (en),
        .flush      (flush),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .dp_i       (dp_i),
        .dp_s       (dp_s),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .done       (done),
        .stats_gnt  (stats_gnt),
        .stats_stall(stats_stall)
    );

    always #5 CLK = ~CLK;

    // Bench datapath: no reset, two register stages, an arbitrary 3-bit
    // function chosen so that the four operands give distinct results.
    function automatic logic [2:0] dp_fn(input logic [3:0] a);
        return a[2:0] ^ {3{a[3]}};
    endfunction

    logic [3:0] dp_r1;
    logic [2:0] dp_r2;
    always @(posedge CLK) begin
        dp_r1 <= dp_i;
        dp_r2 <= dp_fn(dp_r1);
    end
    assign dp_s = dp_r2;

    logic [3:0] op_tab [4];

    typedef struct {
        logic [2:0] id;
        logic [2:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;
    int   m_gnt    = 0;
    int   m_stall  = 0;
    logic mon_en   = 1'b0;
    logic s_done;
    logic s_busy;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc_cnt);
        end
    endtask

    // Call just after a rising edge. Drives req for one cycle, checks the
    // combinational grant at the falling edge, records the scoreboard entry
    // and the stats model, then returns just after the next rising edge.
    task automatic step_cycle(input logic [3:0] rq, input int exp_id);
        logic [3:0] eg;
        eg  = 4'b0000;
        req = rq;
        if (exp_id >= 0) eg[exp_id[1:0]] = 1'b1;
        @(negedge CLK);
        check_val("gnt", {28'b0, gnt}, {28'b0, eg});
        if (exp_id < 0) begin
            check_val("dp_i_idle", {28'b0, dp_i}, 32'h0);
            if (rq != 4'b0000) m_stall++;
        end else begin
            check_val("dp_i", {28'b0, dp_i}, {28'b0, op_tab[exp_id[1:0]]});
            sb.push_back('{id: 3'(exp_id), data: dp_fn(op_tab[exp_id[1:0]]), due: cyc_cnt + LAT});
            m_gnt++;
        end
        s_done = done;
        s_busy = busy;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_stats();
`ifdef DP_SCHED_STATS_EN
        check_val("stats_gnt", {16'b0, stats_gnt}, m_gnt);
        check_val("stats_stall", {16'b0, stats_stall}, m_stall);
`else
        check_val("stats_gnt_off", {16'b0, stats_gnt}, 32'h0);
        check_val("stats_stall_off", {16'b0, stats_stall}, 32'h0);
`endif
    endtask

    // Response monitor
    always @(negedge CLK) begin
        if (mon_en) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_val("rsp_spurious", {31'b0, rsp_valid}, 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("rsp_id", {29'b0, rsp_id}, {29'b0, mon_e.id});
                    check_val("rsp_data", {29'b0, rsp_data}, {29'b0, mon_e.data});
                    check_val("rsp_cycle", cyc_cnt, mon_e.due);
                end
            end else begin
                check_val("rsp_data_idle", {29'b0, rsp_data}, 32'h0);
                if (sb.size() != 0 && sb[0].due <= cyc_cnt) begin
                    check_val("rsp_missing", {31'b0, rsp_valid}, 32'h1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        op_tab[0] = 4'hC;
        op_tab[1] = 4'h6;
        op_tab[2] = 4'hA;
        op_tab[3] = 4'h4;
        req_data  = {op_tab[3], op_tab[2], op_tab[1], op_tab[0]};
        RST_N = 1'b0;
        en    = 1'b0;
        flush = 1'b0;
        req   = '0;

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        check_val("rst_gnt", {28'b0, gnt}, 32'h0);
        check_val("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check_val("rst_busy", {31'b0, busy}, 32'h0);
        check_val("rst_done", {31'b0, done}, 32'h0);
        check_stats();
        @(posedge CLK);
        #1;
        RST_N  = 1'b1;
        mon_en = 1'b1;

        // Single request, response LAT cycles later
        en = 1'b1;
        step_cycle(4'b0000, -1);
        check_val("idle_busy", {31'b0, s_busy}, 32'h0);
        step_cycle(4'b0100, 2);
        check_val("run_busy", {31'b0, s_busy}, 32'h1);
        step_cycle(4'b0000, -1);
        step_cycle(4'b0000, -1);

        // Round-robin from pointer 0
        step_cycle(4'b1000, 3);
        for (int i = 0; i < 8; i++) step_cycle(4'b1111, i % 4);

        // Wrap and skip from pointer 3
        step_cycle(4'b0100, 2);
        step_cycle(4'b1001, 3);
        step_cycle(4'b1001, 0);
        step_cycle(4'b1001, 3);
        step_cycle(4'b0000, -1);

        // Three requesters for ten cycles, then en=0 for five cycles
        for (int i = 0; i < 10; i++) step_cycle(4'b0111, i % 3);
        check_stats();
        en = 1'b0;
        for (int i = 0; i < 5; i++) step_cycle(4'b0111, -1);
        check_stats();
        check_val("en_off_busy", {31'b0, s_busy}, 32'h0);

        // Flush in RUN with all requesters active
        en = 1'b1;
        step_cycle(4'b0000, -1);
        step_cycle(4'b1111, 1);
        step_cycle(4'b1111, 2);
        flush = 1'b1;
        step_cycle(4'b1111, -1);
        check_val("flush_done0", {31'b0, s_done}, 32'h0);
        flush = 1'b0;
        step_cycle(4'b1111, -1);
        check_val("drain_done0", {31'b0, s_done}, 32'h0);
        check_val("drain_busy", {31'b0, s_busy}, 32'h1);
        step_cycle(4'b1111, -1);
        check_val("drain_done1", {31'b0, s_done}, 32'h1);
        en = 1'b0;
        step_cycle(4'b1111, -1);
        check_val("post_drain_done", {31'b0, s_done}, 32'h0);
        check_val("post_drain_busy", {31'b0, s_busy}, 32'h0);

        // Flush while IDLE
        flush = 1'b1;
        step_cycle(4'b0000, -1);
        check_val("iflush_done0", {31'b0, s_done}, 32'h0);
        flush = 1'b0;
        step_cycle(4'b0000, -1);
        check_val("iflush_done1", {31'b0, s_done}, 32'h1);
        step_cycle(4'b0000, -1);
        check_val("iflush_done2", {31'b0, s_done}, 32'h0);
        check_val("iflush_busy", {31'b0, s_busy}, 32'h0);
        check_stats();

        // Reset with two tags in flight
        en = 1'b1;
        step_cycle(4'b0000, -1);
        step_cycle(4'b0011, 0);
        step_cycle(4'b0010, 1);
        mon_en = 1'b0;
        sb.delete();
        req = 4'b0011;
        #2;
        RST_N = 1'b0;
        #1;
        check_val("arst_gnt", {28'b0, gnt}, 32'h0);
        check_val("arst_dp_i", {28'b0, dp_i}, 32'h0);
        check_val("arst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check_val("arst_rsp_id", {29'b0, rsp_id}, 32'h0);
        check_val("arst_rsp_data", {29'b0, rsp_data}, 32'h0);
        check_val("arst_busy", {31'b0, busy}, 32'h0);
        check_val("arst_done", {31'b0, done}, 32'h0);
        check_val("arst_stats", {stats_gnt, stats_stall}, 32'h0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        req   = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check_val("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
            check_val("post_rst_rsp_data", {29'b0, rsp_data}, 32'h0);
            @(posedge CLK);
            #1;
        end
        mon_en = 1'b1;
        step_cycle(4'b1111, 0);
        step_cycle(4'b0000, -1);
        step_cycle(4'b0000, -1);
        en = 1'b0;
        step_cycle(4'b0000, -1);
        check_val("sb_empty", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
